// File: rtl/pulse_window_counter_if.sv
// Result port bundle for pulse_window_counter: start/pulse inputs and the
// valid/ready count output with status flags.
interface pulse_window_counter_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             din;
   logic             cnt_ready;
   logic [CNT_W-1:0] cnt_out;
   logic             cnt_valid;
   logic             busy;
   logic             sat;

   modport master (
      output start, din, cnt_ready,
      input  cnt_out, cnt_valid, busy, sat
   );

   modport slave (
      input  start, din, cnt_ready,
      output cnt_out, cnt_valid, busy, sat
   );
endinterface

// File: rtl/pulse_window_counter.sv
// Counts rising edges of din over a WIN_LEN-cycle window after start and
// holds the saturating count on a valid/ready port until it is accepted.
module pulse_window_counter #(
   parameter int WIN_LEN = 16,
   parameter int CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   pulse_window_counter_if.slave  bus
);
   localparam int               WC_W     = $clog2(WIN_LEN);
   localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WIN_LEN - 1);
   localparam logic [CNT_W-1:0] ACC_MAX  = '1;

   typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

   state_t           state, state_nxt;
   logic             din_q;
   logic             edge_hit;
   logic             last;
   logic [WC_W-1:0]  win_cnt;
   logic [CNT_W-1:0] acc, acc_nxt;
   logic [CNT_W-1:0] cnt_out;
   logic             cnt_valid;
   logic             sat, sat_nxt;

   assign edge_hit = bus.din & ~din_q;
   assign last     = (win_cnt == WIN_LAST);

   // Accumulator with this cycle's edge folded in; the final window cycle
   // reports this value so its edge is not lost.
   always_comb begin
      acc_nxt = acc;
      sat_nxt = sat;
      if (edge_hit) begin
         if (acc == ACC_MAX) sat_nxt = 1'b1;
         else                acc_nxt = acc + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start)     state_nxt = MEASURE;
         MEASURE: if (last)          state_nxt = REPORT;
         REPORT:  if (bus.cnt_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         din_q     <= 1'b0;
         win_cnt   <= '0;
         acc       <= '0;
         cnt_out   <= '0;
         cnt_valid <= 1'b0;
         sat       <= 1'b0;
      end else begin
         din_q <= bus.din;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  win_cnt <= '0;
                  acc     <= '0;
                  sat     <= 1'b0;
               end
            end
            MEASURE: begin
               acc     <= acc_nxt;
               sat     <= sat_nxt;
               win_cnt <= win_cnt + WC_W'(1);
               if (last) begin
                  cnt_out   <= acc_nxt;
                  cnt_valid <= 1'b1;
               end
            end
            REPORT: begin
               if (bus.cnt_ready) cnt_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.cnt_out   = cnt_out;
   assign bus.cnt_valid = cnt_valid;
   assign bus.sat       = sat;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_pulse_window_counter.sv
// Directed bench: one 8-bit and one 3-bit counter driven in parallel with
// hand-computed edge counts, latency, hold, reset-abort and back-to-back runs.
module tb_pulse_window_counter;
   logic clk = 1'b0;
   logic rst, start, din, cnt_ready;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pulse_window_counter_if #(.CNT_W(8)) bus8 ();
   pulse_window_counter_if #(.CNT_W(3)) bus3 ();

   assign bus8.start     = start;
   assign bus8.din       = din;
   assign bus8.cnt_ready = cnt_ready;
   assign bus3.start     = start;
   assign bus3.din       = din;
   assign bus3.cnt_ready = cnt_ready;

   pulse_window_counter #(.WIN_LEN(16), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   pulse_window_counter #(.WIN_LEN(16), .CNT_W(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // start sampled at edge 0, then 16 MEASURE cycles; returns in cycle 17.
   // toggle=1: din is 0 in the first MEASURE cycle and alternates after.
   task automatic run_window(input bit toggle);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         din = toggle ? (i % 2 == 1) : 1'b1;
         chk("busy_measure", bus8.busy, 1);
         if (i == 15) chk("valid_cycle16", bus8.cnt_valid, 0);
         step();
      end
      chk("valid_cycle17", bus8.cnt_valid, 1);
   endtask

   task automatic accept();
      cnt_ready = 1'b1;
      step();
      chk("accept_valid", bus8.cnt_valid, 0);
      chk("accept_busy", bus8.busy, 0);
      cnt_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; din = 1'b0; cnt_ready = 1'b0;
      step();
      step();
      chk("rst_out", bus8.cnt_out, 0);
      chk("rst_valid", bus8.cnt_valid, 0);
      chk("rst_busy", bus8.busy, 0);
      chk("rst_sat", bus8.sat, 0);
      rst = 1'b0;
      step();

      // din already high before start: no edges counted
      din = 1'b1;
      step();
      run_window(1'b0);
      chk("t1_out", bus8.cnt_out, 0);
      chk("t1_sat", bus8.sat, 0);
      chk("t1_out3", bus3.cnt_out, 0);
      accept();

      // toggling din: 8 edges; 3-bit version saturates at 7
      din = 1'b0;
      step();
      run_window(1'b1);
      chk("t2_out", bus8.cnt_out, 8);
      chk("t2_sat", bus8.sat, 0);
      chk("t3_out", bus3.cnt_out, 7);
      chk("t3_sat", bus3.sat, 1);
      accept();

      // result held under backpressure; start ignored while busy
      run_window(1'b1);
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         step();
         chk("t4_valid", bus8.cnt_valid, 1);
         chk("t4_out", bus8.cnt_out, 8);
         chk("t4_busy", bus8.busy, 1);
      end
      start = 1'b0;
      accept();
      step();
      chk("t4_idle", bus8.busy, 0);

      // reset in the 6th MEASURE cycle aborts with no result
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         din = (i % 2 == 1);
         step();
      end
      rst = 1'b1;
      din = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_out", bus8.cnt_out, 0);
      chk("t5_valid", bus8.cnt_valid, 0);
      chk("t5_busy", bus8.busy, 0);
      chk("t5_sat", bus8.sat, 0);
      chk("t5_sat3", bus3.sat, 0);
      for (int i = 0; i < 20; i++) begin
         din = ~din;
         step();
         chk("t5_no_valid", bus8.cnt_valid, 0);
         chk("t5_no_busy", bus8.busy, 0);
      end

      // back-to-back: 1-cycle valid pulse every 18 cycles
      cnt_ready = 1'b1;
      start = 1'b1;
      din = 1'b0;
      step();
      for (int c = 1; c <= 54; c++) begin
         din = ~din;
         chk("t6_valid", bus8.cnt_valid, (c % 18 == 17));
         chk("t6_busy", bus8.busy, (c % 18 != 0));
         if (c % 18 == 17) chk("t6_out", bus8.cnt_out, 8);
         step();
      end
      start = 1'b0;
      cnt_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
